// File: rtl/div_pkg.sv
// Shared types and helpers for the parametrised sequential divider.
// State encoding, magnitude helper and counter sizing live here.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    // Widest operand the magnitude helper supports; callers cast down to WIDTH.
    localparam int DIV_MAX_W     = 64;
    localparam int DIV_DEFAULT_W = 32;

    // Iteration counter must be able to hold the value WIDTH.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int DIV_DEFAULT_CNT_W = div_cnt_w(DIV_DEFAULT_W);

    // Conditional two's-complement negate; MIN maps onto itself, which is its
    // correct magnitude when read as an unsigned value.
    function automatic logic [DIV_MAX_W-1:0] abs_w(input logic [DIV_MAX_W-1:0] val,
                                                   input logic                 neg);
        logic [DIV_MAX_W-1:0] res;
        if (neg) begin
            res = ~val + {{(DIV_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_W
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {2'b00, i_dvs};
    assign w_fits  = ~w_diff[WIDTH+1];

    // Select restored or reduced remainder and shift the quotient bit in.
    always_comb begin
        o_rem = w_shift[WIDTH:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (w_fits) begin
            o_rem = w_diff[WIDTH:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[WIDTH:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle signed/unsigned integer divider with start/busy handshake,
// early resolution of divide-by-zero and signed MIN/-1, and a one-cycle done pulse.
module div_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             overflow
);

    localparam int               CNT_W     = div_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0] r_quo,    w_quo_nxt;
    logic [WIDTH:0]   r_rem,    w_rem_nxt;
    logic [WIDTH-1:0] r_dvs,    w_dvs_nxt;
    logic             r_neg_q,  w_neg_q_nxt;
    logic             r_neg_r,  w_neg_r_nxt;
    logic [WIDTH-1:0] r_q,      w_q_nxt;
    logic [WIDTH-1:0] r_r,      w_r_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_dz,     w_dz_nxt;
    logic             r_ov,     w_ov_nxt;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    assign w_dvd_mag = WIDTH'(abs_w(DIV_MAX_W'(dividend), is_signed & dividend[WIDTH-1]));
    assign w_dvs_mag = WIDTH'(abs_w(DIV_MAX_W'(divisor),  is_signed & divisor[WIDTH-1]));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // Next-state and next-output logic for the IDLE/CALC/FIX sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_quo_nxt   = r_quo;
        w_rem_nxt   = r_rem;
        w_dvs_nxt   = r_dvs;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = r_dz;
        w_ov_nxt    = r_ov;

        case (r_state)
            IDLE: begin
                if (start) begin
                    if (divisor == ALL_ZERO) begin
                        w_q_nxt    = ALL_ONES;
                        w_r_nxt    = dividend;
                        w_dz_nxt   = 1'b1;
                        w_ov_nxt   = 1'b0;
                        w_done_nxt = 1'b1;
                    end else if (is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES)) begin
                        w_q_nxt    = dividend;
                        w_r_nxt    = ALL_ZERO;
                        w_dz_nxt   = 1'b0;
                        w_ov_nxt   = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = CALC;
                        w_cnt_nxt   = {CNT_W{1'b0}};
                        w_quo_nxt   = w_dvd_mag;
                        w_rem_nxt   = {(WIDTH+1){1'b0}};
                        w_dvs_nxt   = w_dvs_mag;
                        w_neg_q_nxt = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        w_neg_r_nxt = is_signed & dividend[WIDTH-1];
                        w_busy_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            CALC: begin
                w_quo_nxt = w_step_quo;
                w_rem_nxt = w_step_rem;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = FIX;
                end else begin
                    w_state_nxt = CALC;
                end
            end
            FIX: begin
                // Quotient truncates toward zero; remainder follows the dividend sign.
                w_q_nxt     = WIDTH'(abs_w(DIV_MAX_W'(r_quo), r_neg_q));
                w_r_nxt     = WIDTH'(abs_w(DIV_MAX_W'(r_rem[WIDTH-1:0]), r_neg_r));
                w_dz_nxt    = 1'b0;
                w_ov_nxt    = 1'b0;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_quo   <= {WIDTH{1'b0}};
            r_rem   <= {(WIDTH+1){1'b0}};
            r_dvs   <= {WIDTH{1'b0}};
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
            r_dvs   <= w_dvs_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dz    <= w_dz_nxt;
            r_ov    <= w_ov_nxt;
        end
    end

    assign q        = r_q;
    assign r        = r_r;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign overflow = r_ov;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed and table-driven checks of div_seq_param at WIDTH=32, plus a
// WIDTH=8 randomised run against an integer reference model.
module tb_div_seq_param;

    logic        clock;
    logic        reset;
    logic        start, is_signed;
    logic [31:0] dividend, divisor, q, r;
    logic        busy, done, div_zero, overflow;

    logic        start8, sgn8;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic        busy8, done8, dz8, ov8;

    int n_pass  = 0;
    int n_total = 0;

    div_seq_param #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .q(q), .r(r), .busy(busy),
        .done(done), .div_zero(div_zero), .overflow(overflow)
    );

    div_seq_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .is_signed(sgn8),
        .dividend(dvd8), .divisor(dvs8), .q(q8), .r(r8), .busy(busy8),
        .done(done8), .div_zero(dz8), .overflow(ov8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        logic        eov;
        int          elat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation on the 32-bit DUT; returns edges from T0 to done and busy-cycle count.
    task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        @(negedge clock);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0; is_signed = ~sgn; dividend = ~a; divisor = ~b;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bcnt++;
        end
        if (!done) check("done_timeout32", 32'(done), 32'd1);
    endtask

    task automatic run8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
        @(negedge clock);
        start8 = 1'b1; sgn8 = sgn; dvd8 = a; dvs8 = b;
        @(posedge clock); #1;
        start8 = 1'b0; sgn8 = ~sgn; dvd8 = ~a; dvs8 = ~b;
        lat  = 0;
        bcnt = busy8 ? 1 : 0;
        while (!done8 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (busy8) bcnt++;
        end
        if (!done8) check("done_timeout8", 32'(done8), 32'd1);
    endtask

    initial begin
        int lat, bcnt, seen;
        logic [7:0]  a8, b8, eq8, er8;
        logic        s8, edz8, eov8;
        int          elat8, sa, sb, tq, tr;
        logic [15:0] inv;

        vecs[0]  = '{1'b1, 32'd4464,       32'd1,          32'd4464,       32'd0,          1'b0, 1'b0, 33};
        vecs[1]  = '{1'b1, 32'd4464,       32'hFFFFFFFF,   32'hFFFFEE90,   32'd0,          1'b0, 1'b0, 33};
        vecs[2]  = '{1'b1, 32'd4464,       32'd0,          32'hFFFFFFFF,   32'd4464,       1'b1, 1'b0, 0};
        vecs[3]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 33};
        vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1, 0};
        vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0, 33};
        vecs[6]  = '{1'b0, 32'hAAAAAAAA,   32'd32,         32'h05555555,   32'h0000000A,   1'b0, 1'b0, 33};
        vecs[7]  = '{1'b1, 32'hAAAAAAAA,   32'd32,         32'hFD555556,   32'hFFFFFFEA,   1'b0, 1'b0, 33};
        vecs[8]  = '{1'b1, 32'h8FFFFFFF,   32'hFFFFFFFB,   32'h16666666,   32'hFFFFFFFD,   1'b0, 1'b0, 33};
        vecs[9]  = '{1'b0, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1, 1'b0, 0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 1'b0, 33};
        vecs[11] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0, 33};
        vecs[12] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0, 33};

        reset = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = 32'd0; divisor = 32'd0;
        start8 = 1'b0; sgn8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_q", q, 32'd0);
        check("rst_r", r, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_ov", 32'(overflow), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run32(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("v%0d_q", i), q, vecs[i].eq);
            check($sformatf("v%0d_r", i), r, vecs[i].er);
            check($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].edz));
            check($sformatf("v%0d_ov", i), 32'(overflow), 32'(vecs[i].eov));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].elat));
            check($sformatf("v%0d_busy", i), 32'(bcnt), 32'(vecs[i].elat));
        end

        // start while busy is ignored and not queued
        @(negedge clock);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        repeat (2) @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        check("ign_done", 32'(done), 32'd1);
        check("ign_q", q, 32'd14);
        check("ign_r", r, 32'd2);
        @(posedge clock); #1;
        check("ign_noqueue_busy", 32'(busy), 32'd0);
        check("ign_noqueue_done", 32'(done), 32'd0);

        // back-to-back start in the done cycle
        run32(1'b0, 32'd50, 32'd5, lat, bcnt);
        check("b2b1_q", q, 32'd10);
        check("b2b1_done", 32'(done), 32'd1);
        run32(1'b0, 32'd9, 32'd2, lat, bcnt);
        check("b2b2_lat", 32'(lat), 32'd33);
        check("b2b2_q", q, 32'd4);
        check("b2b2_r", r, 32'd1);

        // asynchronous reset mid-operation
        run32(1'b1, 32'd5, 32'd0, lat, bcnt);
        check("pre_rst_dz", 32'(div_zero), 32'd1);
        @(negedge clock);
        start = 1'b1; is_signed = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_q", q, 32'd0);
        check("mid_rst_r", r, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_dz", 32'(div_zero), 32'd0);
        check("mid_rst_ov", 32'(overflow), 32'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        run32(1'b1, 32'd1000, 32'd3, lat, bcnt);
        check("post_rst_q", q, 32'd333);
        check("post_rst_r", r, 32'd1);
        check("post_rst_lat", 32'(lat), 32'd33);

        // WIDTH=8 randomised regression against integer reference
        for (int i = 0; i < 40; i++) begin
            s8 = 1'($urandom_range(1, 0));
            a8 = 8'($urandom_range(255, 0));
            b8 = 8'($urandom_range(255, 0));
            if (i == 0) b8 = 8'd0;
            if (i == 1) begin s8 = 1'b1; a8 = 8'h80; b8 = 8'hFF; end
            if (i == 2) begin s8 = 1'b0; a8 = 8'h80; b8 = 8'hFF; end
            if (b8 == 8'd0) begin
                eq8 = 8'hFF; er8 = a8; edz8 = 1'b1; eov8 = 1'b0; elat8 = 0;
            end else if (s8 && a8 == 8'h80 && b8 == 8'hFF) begin
                eq8 = 8'h80; er8 = 8'd0; edz8 = 1'b0; eov8 = 1'b1; elat8 = 0;
            end else begin
                edz8 = 1'b0; eov8 = 1'b0; elat8 = 9;
                if (s8) begin
                    sa = $signed(a8); sb = $signed(b8);
                end else begin
                    sa = int'(a8); sb = int'(b8);
                end
                tq = sa / sb; tr = sa % sb;
                eq8 = tq[7:0]; er8 = tr[7:0];
            end
            run8(s8, a8, b8, lat, bcnt);
            check($sformatf("w8_%0d_q", i), 32'(q8), 32'(eq8));
            check($sformatf("w8_%0d_r", i), 32'(r8), 32'(er8));
            check($sformatf("w8_%0d_dz", i), 32'(dz8), 32'(edz8));
            check($sformatf("w8_%0d_ov", i), 32'(ov8), 32'(eov8));
            check($sformatf("w8_%0d_lat", i), 32'(lat), 32'(elat8));
            if (elat8 == 9) begin
                inv = q8 * b8 + 16'(r8);
                check($sformatf("w8_%0d_inv", i), 32'(inv[7:0]), 32'(a8));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
